pipe_skid_reg: RTL
==================

# pipe_skid_reg

Two-entry skid-buffered pipeline register placed between adjacent CPU pipeline stages (e.g. IF→ID, EX→MEM). It accepts a payload from the upstream stage under a valid/ready handshake. It presents the payload to the downstream stage one cycle later and absorbs one extra beat when downstream stalls, so `in_ready` is fully registered. A synchronous `flush` squashes in-flight contents on branch redirect.

## Interface
- `width`, 32, payload width in bits (≥1)
- `clk` input 1 — rising-edge clock
- `rst_n` input 1 — asynchronous, active-low reset
- `flush` input 1 — synchronous squash of all held entries
- `in_valid` input 1 — upstream payload valid
- `in_ready` output 1 — block can accept a beat this cycle (registered)
- `in_data` input `width` — upstream payload
- `out_valid` output 1 — `out_data` is valid (registered)
- `out_ready` input 1 — downstream accepts this cycle
- `out_data` output `width` — payload to downstream (registered)
- `occupancy` output 2 — entries held: 0, 1 or 2

## Operation
- Storage: main slot (drives `out_*`) and skid slot. States EMPTY (0 held), BUSY (main only), FULL (main+skid).
- Accept = `in_valid & in_ready`; emit = `out_valid & out_ready`.
- EMPTY: accept → main ← `in_data`, go BUSY.
- BUSY, accept & emit → main ← `in_data`, stay BUSY.
- BUSY, accept & no emit → skid ← `in_data`, go FULL.
- BUSY, emit & no accept → go EMPTY.
- BUSY, neither → hold.
- FULL: `in_ready`=0, so no accept is possible. Emit → main ← skid, go BUSY. No emit → hold.
- `in_ready` = 1 in EMPTY/BUSY, 0 in FULL. `out_valid` = 1 in BUSY/FULL.
- `occupancy` is 0/1/2 for EMPTY/BUSY/FULL.
- `flush`=1 has priority: next state EMPTY, and any same-cycle accept is discarded. A same-cycle emit still counts as delivered, because outputs that cycle are registered values.
- Ordering is strict FIFO; no beat is duplicated or dropped except by `flush`.
- Data registers load only on their enables; stale data may remain in the slots while `out_valid`=0.
- `in_data` is captured only when accepted. Payload is not interpreted.

## Timing
- Reset (async assert, sync deassert handled externally): state EMPTY, `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=0, skid=0.
- Latency: a beat accepted in cycle N appears on `out_*` in cycle N+1.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- `in_ready` and all outputs come from flops; there is no combinational path from `out_ready` or `in_valid` to any output.
- Once `out_valid` is asserted, it and `out_data` hold stable until emit or `flush`.
- Upstream may hold `in_valid` and `in_data` regardless of `in_ready`; the block does not require upstream to hold them.
- Reset asserted mid-transfer → immediate return to reset values; held beats are lost.

## Structure
- Shared package `pipe_pkg`: `pipe_state_t` enum {EMPTY, BUSY, FULL}, 2-bit encoding.
- No sub-module. Main and skid slots are plain flop arrays in this module, with one `always_ff` for state and one for data.

## Test plan
- Reset then single beat: `in_data`=0x0000_00AA, `in_valid` for 1 cycle, `out_ready`=1 → `out_valid`=1 with 0xAA next cycle only, `occupancy` 0→1→0.
- Streaming: 8 beats 0x1..0x8 back-to-back, `out_ready`=1 → outputs 0x1..0x8 on consecutive cycles, `in_ready` never drops.
- Stall: send 0x10, 0x11, 0x12 with `out_ready`=0 → `occupancy`=2 and `in_ready`=0 after two accepts. 0x12 is held by upstream. After `out_ready`=1, outputs are 0x10, 0x11, 0x12 in order.
- Flush while FULL with `in_valid`=1 (0x55) → next cycle `occupancy`=0, `out_valid`=0, and 0x55 never appears.
- Flush and emit in the same cycle in BUSY (0x20, `out_ready`=1) → 0x20 counted delivered, state EMPTY.
- Async reset asserted mid-clock while FULL → outputs reach reset values before the next edge. After release, the first beat 0x77 passes with 1-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid register: slot-occupancy state and its count.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
    logic [OCC_W-1:0] occ;
    occ = OCC_W'(0);
    case (s)
      BUSY:    occ = OCC_W'(1);
      FULL:    occ = OCC_W'(2);
      default: occ = OCC_W'(0);
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register; every output, including in_ready,
// comes straight from a flop so no combinational path crosses the stage.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  pipe_state_t      state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [OCC_W-1:0] occupancy_q;
  logic [width-1:0] main_q, main_d, skid_q;
  logic             main_en, skid_en;
  logic             accept_c, emit_c;

  assign accept_c = in_valid & in_ready_q;
  assign emit_c   = out_valid_q & out_ready;

  // Next state and slot load enables; flush overrides everything.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept_c && emit_c) begin
          main_en = 1'b1;
        end else if (accept_c) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (emit_c) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit_c) begin
          main_en = 1'b1;
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  // State plus status outputs, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occupancy_q <= OCC_W'(0);
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      occupancy_q <= occ_of(state_d);
    end
  end

  // Slot storage; slots keep stale contents when not loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= width'(0);
      skid_q <= width'(0);
    end else begin
      if (main_en) main_q <= main_d;
      if (skid_en) skid_q <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occupancy_q;

endmodule
